peridot_avm_arbiter: RTL and testbench

PERIDOT_AVM_ARBITER -- requirements
Module: peridot_avm_arbiter

---
 rtl/peridot_avm_arbiter.sv | 165 ++++++++++++++++
 tb/tb_peridot_avm_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peridot_avm_arbiter.sv
// Purpose: two-port Avalon-MM arbiter. Alternates ownership of one master port with a
//   per-grant command quantum and holds in-order read completion across owner changes.
// Latency: 1-cycle grant from IDLE. Commands pass combinationally while BUSY.
//   Read data and readdatavalid pass combinationally to the current owner.
// Backpressure: the owner sees the slave waitrequest. It is also held off while
//   MAX_PENDING reads are outstanding. The non-owner is always held off.
// Ports:
//   csi_avmclock_clk / csi_avmclock_reset : clock and synchronous active-high reset
//   avs_s0_* / avs_s1_*                   : Avalon-MM slave ports facing the two requesters
//   avm_m1_*                              : Avalon-MM master port facing the shared slave
//   arb_error                             : sticky flag for an unexpected readdatavalid
module peridot_avm_arbiter #(
  parameter int QUANTUM     = 8,
  parameter int MAX_PENDING = 4
) (
  input  logic        csi_avmclock_clk,
  input  logic        csi_avmclock_reset,
  input  logic [31:0] avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [3:0]  avs_s0_byteenable,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        avs_s0_waitrequest,
  output logic        avs_s0_readdatavalid,
  input  logic [31:0] avs_s1_address,
  input  logic        avs_s1_read,
  input  logic        avs_s1_write,
  input  logic [3:0]  avs_s1_byteenable,
  input  logic [31:0] avs_s1_writedata,
  output logic [31:0] avs_s1_readdata,
  output logic        avs_s1_waitrequest,
  output logic        avs_s1_readdatavalid,
  output logic [31:0] avm_m1_address,
  output logic        avm_m1_read,
  output logic        avm_m1_write,
  output logic [3:0]  avm_m1_byteenable,
  output logic [31:0] avm_m1_writedata,
  input  logic [31:0] avm_m1_readdata,
  input  logic        avm_m1_waitrequest,
  input  logic        avm_m1_readdatavalid,
  output logic        arb_error
);

  localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);
  // qcnt holds commands already accepted in this grant, so the quantum is
  // reached when an accept happens while qcnt sits at QUANTUM-1.
  localparam logic [7:0] Q_LAST   = 8'(QUANTUM - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last, last_nxt;
  logic [3:0]  pending, pending_nxt;
  logic [7:0]  qcnt, qcnt_nxt;
  logic        arb_error_nxt;

  logic        s0_req, s1_req;
  logic        own_read, own_write, own_req, oth_req;
  logic [31:0] own_address, own_writedata;
  logic [3:0]  own_byteenable;
  logic        blocked, accept, rdv_ok;

  assign s0_req         = avs_s0_read | avs_s0_write;
  assign s1_req         = avs_s1_read | avs_s1_write;
  assign own_read       = owner ? avs_s1_read       : avs_s0_read;
  assign own_write      = owner ? avs_s1_write      : avs_s0_write;
  assign own_address    = owner ? avs_s1_address    : avs_s0_address;
  assign own_writedata  = owner ? avs_s1_writedata  : avs_s0_writedata;
  assign own_byteenable = owner ? avs_s1_byteenable : avs_s0_byteenable;
  assign own_req        = own_read | own_write;
  assign oth_req        = owner ? s0_req : s1_req;

  // Writes are throttled together with reads at the pending limit so a later
  // write can never overtake an earlier read that is still being held off.
  assign blocked = (pending == PEND_MAX);
  assign accept  = (state == BUSY) & own_req & ~blocked & ~avm_m1_waitrequest;

  // A return is only legitimate when a read is actually outstanding; anything
  // else is swallowed here and reported through arb_error.
  assign rdv_ok  = avm_m1_readdatavalid & (state != IDLE) & (pending != 4'd0);

  assign avs_s0_readdata      = avm_m1_readdata;
  assign avs_s1_readdata      = avm_m1_readdata;
  assign avs_s0_readdatavalid = rdv_ok & ~owner;
  assign avs_s1_readdatavalid = rdv_ok & owner;

  always_ff @(posedge csi_avmclock_clk) begin
    if (csi_avmclock_reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      pending   <= 4'd0;
      qcnt      <= 8'd0;
      arb_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      pending   <= pending_nxt;
      qcnt      <= qcnt_nxt;
      arb_error <= arb_error_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    owner_nxt          = owner;
    last_nxt           = last;
    qcnt_nxt           = qcnt;
    pending_nxt        = pending;
    arb_error_nxt      = arb_error | (avm_m1_readdatavalid & ~rdv_ok);
    avm_m1_address     = own_address;
    avm_m1_writedata   = own_writedata;
    avm_m1_byteenable  = own_byteenable;
    avm_m1_read        = 1'b0;
    avm_m1_write       = 1'b0;
    avs_s0_waitrequest = 1'b1;
    avs_s1_waitrequest = 1'b1;

    unique case (state)
      IDLE: begin
        if (s0_req || s1_req) begin
          // On a tie the port that did not hold the previous grant wins.
          owner_nxt = (s0_req && s1_req) ? ~last : s1_req;
          qcnt_nxt  = 8'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        avm_m1_read  = own_read & ~blocked;
        avm_m1_write = own_write & ~blocked;
        if (owner) avs_s1_waitrequest = blocked | avm_m1_waitrequest;
        else       avs_s0_waitrequest = blocked | avm_m1_waitrequest;
        if (!own_req) begin
          state_nxt = DRAIN;
        end else if (accept) begin
          if (qcnt == Q_LAST) begin
            // Quantum used up: yield only if the other port wants the bus,
            // otherwise start a fresh quantum for the same owner.
            qcnt_nxt = 8'd0;
            if (oth_req) state_nxt = DRAIN;
          end else begin
            qcnt_nxt = qcnt + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (pending == 4'd0) begin
          last_nxt  = owner;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case ({accept & own_read, rdv_ok})
      2'b10:   pending_nxt = pending + 4'd1;
      2'b01:   pending_nxt = pending - 4'd1;
      default: pending_nxt = pending;
    endcase
  end

endmodule

// File: tb/tb_peridot_avm_arbiter.sv
// Bench for peridot_avm_arbiter: requester drivers push expected commands and read data into
// queues when the arbiter accepts them. A monitor pops and compares whenever the master
// port issues or a port receives readdatavalid. A behavioural slave returns reads in order.
module tb_peridot_avm_arbiter;
  localparam int Q  = 8;
  localparam int MP = 4;

  typedef struct { int port; bit isrd; logic [31:0] a; logic [31:0] d; logic [3:0] b; } cmd_t;
  typedef struct { logic [31:0] data; int due; int port; } ret_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd [2];
  logic wr [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [3:0] be [2];
  logic [31:0] rdat [2];
  logic wreq [2];
  logic rvld [2];
  logic [31:0] m_addr, m_wdat, s_rdat;
  logic m_rd, m_wr, s_wait, s_rdv, s_stray, arb_err;
  logic [3:0] m_be;
  int s_port;

  int total = 0, bad = 0, cyc = 0, mcount = 0, credit = -1, lat_cfg = 3, last_due = 0;
  bit wait_rand = 0, force_wait = 0, inject = 0, abort = 0;
  cmd_t mexp[$];
  logic [31:0] dexp0[$];
  logic [31:0] dexp1[$];
  ret_t ret[$];
  int glog[$];

  always #5 clk = ~clk;

  peridot_avm_arbiter #(.QUANTUM(Q), .MAX_PENDING(MP)) dut (
    .csi_avmclock_clk(clk), .csi_avmclock_reset(rst),
    .avs_s0_address(addr[0]), .avs_s0_read(rd[0]), .avs_s0_write(wr[0]),
    .avs_s0_byteenable(be[0]), .avs_s0_writedata(wdat[0]), .avs_s0_readdata(rdat[0]),
    .avs_s0_waitrequest(wreq[0]), .avs_s0_readdatavalid(rvld[0]),
    .avs_s1_address(addr[1]), .avs_s1_read(rd[1]), .avs_s1_write(wr[1]),
    .avs_s1_byteenable(be[1]), .avs_s1_writedata(wdat[1]), .avs_s1_readdata(rdat[1]),
    .avs_s1_waitrequest(wreq[1]), .avs_s1_readdatavalid(rvld[1]),
    .avm_m1_address(m_addr), .avm_m1_read(m_rd), .avm_m1_write(m_wr),
    .avm_m1_byteenable(m_be), .avm_m1_writedata(m_wdat), .avm_m1_readdata(s_rdat),
    .avm_m1_waitrequest(s_wait), .avm_m1_readdatavalid(s_rdv),
    .arb_error(arb_err)
  );

  // Contents of the shared slave as seen by any reader.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hCAFEF00D;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Present one command on port p and hold it until accepted. Call at posedge+1.
  task automatic issue(input int p, input bit isrd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    int n = 0;
    bit done = 0;
    cmd_t e;
    rd[p] = isrd; wr[p] = !isrd; addr[p] = a; wdat[p] = d; be[p] = b;
    while (!done) begin
      @(negedge clk);
      if (abort) begin
        done = 1;
      end else if (!wreq[p]) begin
        e.port = p; e.isrd = isrd; e.a = a; e.d = d; e.b = b;
        mexp.push_back(e);
        if (isrd) begin
          if (p == 0) dexp0.push_back(rd_model(a));
          else        dexp1.push_back(rd_model(a));
        end
        done = 1;
      end else if (++n > 2000) begin
        total++; bad++;
        $display("FAIL issue_timeout: port %0d still waiting after %0d cycles", p, n);
        done = 1;
      end
      @(posedge clk); #1;
    end
    rd[p] = 1'b0; wr[p] = 1'b0;
  endtask

  task automatic run_rand(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      issue(p, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((mexp.size() + dexp0.size() + dexp1.size() + ret.size()) != 0 && n < 1000) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_mrd"},   64'(m_rd), 64'd0);
    chk({tag, "_mwr"},   64'(m_wr), 64'd0);
    chk({tag, "_wreq"},  64'({wreq[0], wreq[1]}), 64'd3);
    chk({tag, "_rvld"},  64'({rvld[0], rvld[1]}), 64'd0);
    chk({tag, "_error"}, 64'(arb_err), 64'd0);
  endtask

  // Behavioural slave: random or forced waitrequest, in-order read return after a latency.
  initial begin
    ret_t r;
    s_wait = 1'b0; s_rdv = 1'b0; s_rdat = 32'h0; s_port = 0; s_stray = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      s_wait  = force_wait || (wait_rand && $urandom_range(0, 3) == 0);
      s_stray = 1'b0;
      if (inject) begin
        s_rdv = 1'b1; s_stray = 1'b1; s_rdat = 32'hDEADBEEF; inject = 0;
      end else if (ret.size() > 0 && ret[0].due <= cyc && credit != 0) begin
        r = ret.pop_front();
        s_rdv = 1'b1; s_rdat = r.data; s_port = r.port;
        if (credit > 0) credit--;
      end else begin
        s_rdv = 1'b0; s_rdat = $urandom;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    cmd_t e;
    ret_t r;
    int foreign, l;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if ((m_rd || m_wr) && !s_wait) begin
          chk("cmd_expected_count", 64'(mexp.size()), 64'd1);
          if (mexp.size() > 0) begin
            e = mexp.pop_front();
            chk("cmd_ctl", 64'({m_rd, m_wr, m_be}), 64'({e.isrd, !e.isrd, e.b}));
            chk("cmd_addr_data", {m_addr, m_wr ? m_wdat : 32'h0}, {e.a, e.isrd ? 32'h0 : e.d});
            foreign = 0;
            foreach (ret[i]) if (ret[i].port != e.port) foreign++;
            if (s_rdv && !s_stray && s_port != e.port) foreign++;
            chk("order_foreign_reads", 64'(foreign), 64'd0);
            if (e.isrd) begin
              chk("pending_bound", 64'((ret.size() + int'(s_rdv && !s_stray)) < MP), 64'd1);
              l = (lat_cfg < 0) ? int'($urandom_range(1, 6)) : lat_cfg;
              r.data = rd_model(m_addr); r.port = e.port; r.due = cyc + l;
              if (r.due < last_due) r.due = last_due;
              last_due = r.due;
              ret.push_back(r);
            end
            glog.push_back(e.port);
            mcount++;
          end
        end
        if (s_rdv && !s_stray) chk("rdv_route", 64'({rvld[0], rvld[1]}), (s_port == 0) ? 64'd2 : 64'd1);
        else                   chk("rdv_none", 64'({rvld[0], rvld[1]}), 64'd0);
        if (rvld[0]) begin
          chk("rdata0_expected", 64'(dexp0.size() > 0), 64'd1);
          if (dexp0.size() > 0) chk("rdata0", 64'(rdat[0]), 64'(dexp0.pop_front()));
        end
        if (rvld[1]) begin
          chk("rdata1_expected", 64'(dexp1.size() > 0), 64'd1);
          if (dexp1.size() > 0) chk("rdata1", 64'(rdat[1]), 64'(dexp1.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int p = 0; p < 2; p++) begin
      rd[p] = 1'b0; wr[p] = 1'b0; addr[p] = 32'h0; wdat[p] = 32'h0; be[p] = 4'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Tie after reset: s0 first, then strict alternation in runs of Q writes.
    glog.delete();
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 24; i++) issue(0, 1'b0, $urandom, $urandom, 4'hF);
      for (int i = 0; i < 24; i++) issue(1, 1'b0, $urandom, $urandom, 4'hF);
    join
    chk("tie_count", 64'(glog.size()), 64'd48);
    for (int i = 0; i < glog.size() && i < 48; i++) chk("tie_seq", 64'(glog[i]), 64'((i / Q) % 2));
    drain();

    // Single read with one IDLE cycle of grant latency.
    lat_cfg = 3;
    @(posedge clk); #1;
    fork
      issue(0, 1'b1, 32'h100, 32'h0, 4'hF);
      begin
        @(negedge clk);
        chk("single_idle_mrd", 64'(m_rd), 64'd0);
        chk("single_idle_wreq", 64'(wreq[0]), 64'd1);
        @(negedge clk);
        chk("single_busy_mrd", 64'(m_rd), 64'd1);
        chk("single_busy_addr", 64'(m_addr), 64'h100);
        chk("single_busy_wreq", 64'(wreq[0]), 64'd0);
      end
    join
    drain();

    // Pending limit: only MP reads escape while the slave withholds data.
    credit = 0; lat_cfg = 1; base = mcount;
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 6; i++) issue(1, 1'b1, 32'h400 + 32'(i) * 4, 32'h0, 4'hF);
      begin
        repeat (20) @(negedge clk);
        #2;
        chk("plim_four", 64'(mcount - base), 64'd4);
        chk("plim_wreq", 64'(wreq[1]), 64'd1);
        chk("plim_mrd", 64'(m_rd), 64'd0);
        credit = 1;
        repeat (5) @(negedge clk);
        #2;
        chk("plim_five", 64'(mcount - base), 64'd5);
        credit = -1;
      end
    join
    drain();

    // Drain ordering: s1 waits for both outstanding s0 reads.
    lat_cfg = 8;
    @(posedge clk); #1;
    fork
      begin
        issue(0, 1'b1, 32'h500, 32'h0, 4'hF);
        issue(0, 1'b1, 32'h504, 32'h0, 4'hF);
      end
      begin
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h600, 32'h1234, 4'h3);
      end
    join
    drain();

    // Stray readdatavalid in IDLE.
    @(negedge clk); #2;
    chk("err_before", 64'(arb_err), 64'd0);
    inject = 1;
    @(negedge clk); #2;
    chk("err_rdv_driven", 64'(s_rdv), 64'd1);
    chk("err_no_rvld", 64'({rvld[0], rvld[1]}), 64'd0);
    @(negedge clk); #2;
    chk("err_set", 64'(arb_err), 64'd1);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(arb_err), 64'd1);

    // Reset while BUSY with three reads outstanding.
    credit = 0; lat_cfg = 3; base = mcount;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 3; i++) issue(0, 1'b1, 32'h700 + 32'(i) * 4, 32'h0, 4'hF);
        issue(0, 1'b1, 32'h7F0, 32'h0, 4'hF);
      end
      begin
        int n = 0;
        while ((mcount - base) < 3 && n < 200) begin @(negedge clk); #2; n++; end
        force_wait = 1;
        chk("mid_three_pending", 64'(mcount - base), 64'd3);
        repeat (2) @(posedge clk);
        #1;
        abort = 1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mexp.delete(); dexp0.delete(); dexp1.delete(); ret.delete();
        last_due = 0; force_wait = 0;
        @(negedge clk);
        reset_checks("mid_reset");
        abort = 0;
      end
    join

    // After the reset, a full MP reads must be accepted again.
    base = mcount;
    @(posedge clk); #1;
    for (int i = 0; i < MP; i++) issue(0, 1'b1, 32'h800 + 32'(i) * 4, 32'h0, 4'hF);
    @(negedge clk); #2;
    chk("post_reset_pending_cleared", 64'(mcount - base), 64'(MP));
    credit = -1;
    drain();

    // Randomised traffic on both ports.
    wait_rand = 1; lat_cfg = -1;
    @(posedge clk); #1;
    fork
      run_rand(0, 150);
      run_rand(1, 150);
    join
    wait_rand = 0;
    drain();
    chk("end_cmd_queue", 64'(mexp.size()), 64'd0);
    chk("end_rdata0_queue", 64'(dexp0.size()), 64'd0);
    chk("end_rdata1_queue", 64'(dexp1.size()), 64'd0);
    chk("end_slave_queue", 64'(ret.size()), 64'd0);
    chk("end_no_error", 64'(arb_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
